// File: rtl/txn_wdt_pkg.sv
// Shared definitions for the transaction watchdog scheduler.
// Holds the FSM state encoding, default parameter values and the
// width of the saturating timeout counter.
package txn_wdt_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_TIMEOUT = 5;
    localparam int unsigned TCOUNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } wdt_state_t;

endpackage : txn_wdt_pkg

// File: rtl/wdt_rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req    - level request vector
//   ptr    - index of the last granted requester; search starts at ptr+1
//   onehot - one-hot selected requester (all zero when valid is low)
//   idx    - binary index of the selected requester
//   valid  - at least one request is present
module wdt_rr_arbiter
    import txn_wdt_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    // Walk the requesters starting just after ptr, wrapping; first hit wins.
    always_comb begin : arb_search
        int unsigned cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[IW'(cand)]) begin
                valid              = 1'b1;
                idx                = IW'(cand);
                onehot[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule : wdt_rr_arbiter

// File: rtl/txn_watchdog_scheduler.sv
// Round-robin transaction scheduler with a per-transaction watchdog.
// One transaction is outstanding at a time: a requester is picked in IDLE,
// started in ISSUE, watched for completion in WAIT and answered in RESP.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   req            - level request per requester
//   gnt            - one-cycle one-hot grant pulse
//   tgt_start      - one-cycle start pulse to the shared target
//   tgt_id         - index of the granted requester, held ISSUE..RESP
//   tgt_done       - completion pulse from the target
//   tgt_abort      - one-cycle abort pulse on timeout
//   resp_valid     - one-cycle response pulse
//   resp_id        - requester the response belongs to
//   resp_err       - response status, 1 = timeout (pulses with resp_valid)
//   busy           - high in every state except IDLE
//   timeout_count  - saturating number of timeouts
//   stray_done     - sticky: tgt_done seen outside WAIT
module txn_watchdog_scheduler
    import txn_wdt_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       tgt_start,
    output logic [$clog2(NUM_REQ)-1:0] tgt_id,
    input  logic                       tgt_done,
    output logic                       tgt_abort,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_err,
    output logic                       busy,
    output logic [TCOUNT_W-1:0]        timeout_count,
    output logic                       stray_done
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    // WAIT cycle k (k = 1..TIMEOUT after tgt_start) sees cnt == k-1,
    // so the last WAIT cycle is the one where cnt == TIMEOUT-1.
    localparam logic [CW-1:0]       CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0]       PTR_RST  = IW'(NUM_REQ - 1);
    localparam logic [TCOUNT_W-1:0] TC_MAX   = {TCOUNT_W{1'b1}};

    wdt_state_t          state;
    logic [IW-1:0]       ptr;
    logic [CW-1:0]       cnt;

    logic [NUM_REQ-1:0]  arb_onehot;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;

    wdt_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    // Scheduler FSM with registered outputs; pulse outputs default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= PTR_RST;
            cnt           <= '0;
            gnt           <= '0;
            tgt_start     <= 1'b0;
            tgt_id        <= '0;
            tgt_abort     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_err      <= 1'b0;
            busy          <= 1'b0;
            timeout_count <= '0;
            stray_done    <= 1'b0;
        end else begin
            gnt        <= '0;
            tgt_start  <= 1'b0;
            tgt_abort  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;

            // A completion is only meaningful while waiting for one.
            if (tgt_done && (state != WAIT)) begin
                stray_done <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        tgt_id    <= arb_idx;
                        gnt       <= arb_onehot;
                        tgt_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= '0;
                    ptr   <= tgt_id;
                    state <= WAIT;
                end

                WAIT: begin
                    // Completion beats a simultaneous timeout.
                    if (tgt_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= tgt_id;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_id    <= tgt_id;
                        resp_err   <= 1'b1;
                        tgt_abort  <= 1'b1;
                        if (timeout_count != TC_MAX) begin
                            timeout_count <= timeout_count + TCOUNT_W'(1);
                        end
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : txn_watchdog_scheduler

// File: tb/tb_txn_watchdog_scheduler.sv
// Self-checking bench for txn_watchdog_scheduler: a directed vector table,
// hand-written corner sequences and randomized traffic, all checked against
// a transaction-timeline reference model every cycle.
module tb_txn_watchdog_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         tgt_start;
    logic [1:0]   tgt_id;
    logic         tgt_done;
    logic         tgt_abort;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic         resp_err;
    logic         busy;
    logic [7:0]   timeout_count;
    logic         stray_done;

    txn_watchdog_scheduler #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .gnt           (gnt),
        .tgt_start     (tgt_start),
        .tgt_id        (tgt_id),
        .tgt_done      (tgt_done),
        .tgt_abort     (tgt_abort),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_err      (resp_err),
        .busy          (busy),
        .timeout_count (timeout_count),
        .stray_done    (stray_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: timeline of the single outstanding transaction.
    bit m_active;
    int m_issue;
    int m_resp;
    bit m_err;
    int m_id;
    int m_last;
    int m_tc;
    bit m_stray;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_issue  = -10;
        m_resp   = -1;
        m_err    = 1'b0;
        m_id     = 0;
        m_last   = N - 1;
        m_tc     = 0;
        m_stray  = 1'b0;
    endtask

    // Compare every DUT output against the model's view of the current cycle.
    task automatic check_model();
        logic [N-1:0] eg;
        logic e_busy, e_rv;
        logic [31:0] e_v, a_v;
        e_busy = m_active && (cyc >= m_issue) && ((m_resp < 0) || (cyc <= m_resp));
        e_rv   = m_active && (cyc == m_resp);
        eg     = (m_active && cyc == m_issue) ? N'(1 << m_id) : '0;
        e_v = {10'd0, eg, (m_active && cyc == m_issue), e_rv && m_err, e_rv,
               e_rv && m_err, e_busy, m_stray, 8'(m_tc),
               e_busy ? 2'(m_id) : 2'd0, e_rv ? 2'(m_id) : 2'd0};
        a_v = {10'd0, gnt, tgt_start, tgt_abort, resp_valid, resp_err, busy,
               stray_done, timeout_count,
               e_busy ? tgt_id : 2'd0, e_rv ? resp_id : 2'd0};
        chk("model", a_v, e_v);
    endtask

    // Advance the model by the inputs applied in the current cycle.
    task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
        bit in_win, found;
        if (rs) begin
            model_reset();
            return;
        end
        in_win = m_active && (m_resp < 0) && (cyc >= m_issue + 1) && (cyc <= m_issue + TO);
        if (d && !in_win) m_stray = 1'b1;
        if (in_win) begin
            if (d) begin
                m_resp = cyc + 1;
                m_err  = 1'b0;
            end else if (cyc == m_issue + TO) begin
                m_resp = cyc + 1;
                m_err  = 1'b1;
                if (m_tc < 255) m_tc++;
            end
        end else if (m_active && cyc == m_resp) begin
            m_active = 1'b0;
        end else if (!m_active && r != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!found && r[c]) begin
                    found = 1'b1;
                    m_id  = c;
                end
            end
            m_last   = m_id;
            m_active = 1'b1;
            m_issue  = cyc + 1;
            m_resp   = -1;
        end
    endtask

    // One clock cycle: apply inputs, check outputs, step model, move to next cycle.
    task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
        req      = r;
        tgt_done = d;
        rst      = rs;
        check_model();
        model_step(r, d, rs);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        logic         start;
        logic         abort;
        logic         rv;
        logic         rerr;
        logic         busy;
        logic [1:0]   rid;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int t_prev;

        // req=0001 from reset, done at T+3, response at T+4.
        tbl[0] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{4'h1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[2] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[3] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[4] = '{4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[5] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        tbl[6] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        rst      = 1'b1;
        req      = '0;
        tgt_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("reset_state",
            {13'd0, gnt, tgt_start, tgt_abort, resp_valid, resp_err, busy, stray_done,
             timeout_count, tgt_id, resp_id}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl%0d", i),
                {23'd0, gnt, tgt_start, tgt_abort, resp_valid, resp_err, busy},
                {23'd0, tbl[i].gnt, tbl[i].start, tbl[i].abort, tbl[i].rv, tbl[i].rerr, tbl[i].busy});
            if (tbl[i].rv) chk($sformatf("tbl%0d_rid", i), 32'(resp_id), 32'(tbl[i].rid));
            cycle(tbl[i].req, tbl[i].done, 1'b0);
        end

        // Timeout: req=0010, no completion.
        cycle(4'h2, 1'b0, 1'b0);
        chk("to_start", {28'd0, gnt}, 32'h2);
        repeat (TO + 1) cycle(4'h0, 1'b0, 1'b0);
        chk("to_resp", {28'd0, resp_valid, resp_err, tgt_abort, 1'b0}, 32'he);
        chk("to_rid", 32'(resp_id), 32'd1);
        chk("to_count", 32'(timeout_count), 32'd1);
        cycle(4'h0, 1'b0, 1'b0);
        chk("to_busy_low", 32'(busy), 32'd0);

        // Completion in the last WAIT cycle wins over the timeout.
        cycle(4'h1, 1'b0, 1'b0);
        repeat (TO) cycle(4'h0, 1'b0, 1'b0);
        cycle(4'h0, 1'b1, 1'b0);
        chk("tie_resp", {29'd0, resp_valid, resp_err, tgt_abort}, 32'h4);
        chk("tie_count", 32'(timeout_count), 32'd1);
        cycle(4'h0, 1'b0, 1'b0);

        // Round robin with all requests held, one-cycle completions.
        cycle(4'h0, 1'b0, 1'b1);
        t_prev = -1;
        for (int k = 0; k < 5; k++) begin
            cycle(4'hF, 1'b0, 1'b0);
            chk($sformatf("rr_gnt%0d", k), {28'd0, gnt}, 32'(1 << (k % 4)));
            if (t_prev >= 0) chk($sformatf("rr_gap%0d", k), 32'(cyc - t_prev), 32'd4);
            t_prev = cyc;
            cycle(4'hF, 1'b0, 1'b0);
            cycle(4'hF, 1'b1, 1'b0);
            cycle(4'hF, 1'b0, 1'b0);
        end

        // Reset during WAIT abandons the transaction silently.
        cycle(4'h4, 1'b0, 1'b0);
        cycle(4'h0, 1'b0, 1'b0);
        cycle(4'h0, 1'b0, 1'b0);
        cycle(4'h0, 1'b0, 1'b1);
        chk("rstmid_zero",
            {13'd0, gnt, tgt_start, tgt_abort, resp_valid, resp_err, busy, stray_done,
             timeout_count, tgt_id, resp_id}, 32'd0);
        cycle(4'hF, 1'b0, 1'b0);
        chk("rstmid_gnt0", {28'd0, gnt}, 32'h1);
        cycle(4'h0, 1'b0, 1'b0);
        cycle(4'h0, 1'b1, 1'b0);
        cycle(4'h0, 1'b0, 1'b0);

        // Stray completion in IDLE is sticky; timeout counter saturates.
        cycle(4'h0, 1'b1, 1'b0);
        chk("stray_set", 32'(stray_done), 32'd1);
        for (int k = 0; k < 260; k++) begin
            cycle(N'(1 << (k % N)), 1'b0, 1'b0);
            repeat (7) cycle(4'h0, 1'b0, 1'b0);
            if (k == 254) chk("sat_255", 32'(timeout_count), 32'd255);
        end
        chk("sat_hold", 32'(timeout_count), 32'd255);
        chk("stray_sticky", 32'(stray_done), 32'd1);
        cycle(4'h0, 1'b0, 1'b1);
        chk("stray_clr", 32'(stray_done), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(0, 15));
            cycle(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
        end
        cycle(4'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_txn_watchdog_scheduler
